id_operand_unit: RTL and testbench

- Parametrised successor to the single-port ID-stage operand path.
- Provides NUM_READ register-read ports and prioritised forwarding from NUM_FWD downstream stages, plus WB write-through.
- Adds a busy-bit scoreboard for long-latency ops (mul/div) and load-use stall generation.
- Sits between the decoder and the ID/EX pipeline register; the `stall` output freezes IF/ID and bubbles ID/EX.

---
 rtl/id_operand_unit_pkg.sv | 27 ++
 rtl/id_operand_unit_regfile_mp.sv | 46 ++++
 rtl/id_operand_unit.sv | 131 +++++++++++++
 tb/tb_id_operand_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/id_operand_unit_pkg.sv
// ============================================================================
// Module  : id_operand_unit_pkg
// Brief   : Shared widths, defaults and operand-source encoding for the ID
//           operand path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package id_operand_unit_pkg;

    localparam int COMMON_WIDTH     = 32;
    localparam int REG_NUM_DEFAULT  = 32;
    localparam int REG_NUM_WIDTH    = 5;
    localparam int NUM_READ_DEFAULT = 2;
    localparam int NUM_FWD_DEFAULT  = 2;
    localparam int STALL_CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_FWD  = 2'd1,
        SRC_WB   = 2'd2,
        SRC_RF   = 2'd3
    } opnd_src_e;

endpackage

`default_nettype wire

// File: rtl/id_operand_unit_regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Brief   : Multi-read, single-write register file with x0 hardwired to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int AW       = 5,
    parameter int NUM_READ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [NUM_READ*AW-1:0]   raddr_i,
    output logic [NUM_READ*XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] regs_q [REG_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (raddr_i[p*AW +: AW] != '0) begin
                rdata_o[p*XLEN +: XLEN] = regs_q[raddr_i[p*AW +: AW]];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_operand_unit.sv
// ============================================================================
// Module  : id_operand_unit
// Brief   : ID-stage operand resolution with prioritised forwarding, WB
//           write-through, busy-bit scoreboard and stall generation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_operand_unit
    import id_operand_unit_pkg::*;
#(
    parameter int XLEN     = COMMON_WIDTH,
    parameter int REG_NUM  = REG_NUM_DEFAULT,
    parameter int AW       = REG_NUM_WIDTH,
    parameter int NUM_READ = NUM_READ_DEFAULT,
    parameter int NUM_FWD  = NUM_FWD_DEFAULT,
    parameter int CNT_W    = STALL_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_READ*AW-1:0]   rs_addr,
    input  logic [NUM_READ-1:0]      rs_used,
    output logic [NUM_READ*XLEN-1:0] rs_data,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD*AW-1:0]    fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_ready,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     wb_long,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_rd,
    output logic                     stall,
    output logic [REG_NUM-1:0]       busy_vec,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [NUM_READ*XLEN-1:0] rf_rdata;
    logic [REG_NUM-1:0]       busy_q, busy_d;
    logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

    opnd_src_e                src_sel  [NUM_READ];
    logic [XLEN-1:0]          fwd_sel  [NUM_READ];
    logic [NUM_READ-1:0]      fwd_rdy;
    logic [NUM_READ-1:0]      hazard;

    regfile_mp #(
        .XLEN     (XLEN),
        .REG_NUM  (REG_NUM),
        .AW       (AW),
        .NUM_READ (NUM_READ)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wb_en),
        .waddr_i (wb_addr),
        .wdata_i (wb_data),
        .raddr_i (rs_addr),
        .rdata_o (rf_rdata)
    );

    // Bypass paths are masked during reset so the cleared file is what shows.
    always_comb begin
        rs_data = '0;
        hazard  = '0;
        fwd_rdy = '1;
        for (int p = 0; p < NUM_READ; p++) begin
            src_sel[p] = SRC_RF;
            fwd_sel[p] = '0;
            if (rs_addr[p*AW +: AW] == '0) begin
                src_sel[p] = SRC_ZERO;
            end else begin
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (rst_n && fwd_valid[k] && (fwd_rd[k*AW +: AW] == rs_addr[p*AW +: AW])) begin
                        src_sel[p] = SRC_FWD;
                        fwd_sel[p] = fwd_data[k*XLEN +: XLEN];
                        fwd_rdy[p] = fwd_ready[k];
                    end
                end
                if ((src_sel[p] != SRC_FWD) && rst_n && wb_en && (wb_addr == rs_addr[p*AW +: AW])) begin
                    src_sel[p] = SRC_WB;
                end
            end

            case (src_sel[p])
                SRC_ZERO: rs_data[p*XLEN +: XLEN] = '0;
                SRC_FWD:  rs_data[p*XLEN +: XLEN] = fwd_sel[p];
                SRC_WB:   rs_data[p*XLEN +: XLEN] = wb_data;
                default:  rs_data[p*XLEN +: XLEN] = rf_rdata[p*XLEN +: XLEN];
            endcase

            // A long-latency result landing via write-through releases its busy bit now.
            hazard[p] = ((src_sel[p] == SRC_FWD) && !fwd_rdy[p]) ||
                        ((src_sel[p] != SRC_ZERO) && busy_q[rs_addr[p*AW +: AW]] &&
                         !((src_sel[p] == SRC_WB) && wb_long));
        end
    end

    assign stall = rst_n && |(rs_used & hazard);

    // Set is applied after clear so a fresh issue overrides an old completion.
    always_comb begin
        busy_d = busy_q;
        if (wb_en && wb_long) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (sb_set && (sb_rd != '0)) begin
            busy_d[sb_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_vec  = busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_operand_unit.sv
// ============================================================================
// Module  : tb_id_operand_unit
// Brief   : Directed vector table plus scoreboard / reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_operand_unit;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2*AW-1:0]   rs_addr;
    logic [1:0]        rs_used;
    logic [2*XLEN-1:0] rs_data;
    logic [1:0]        fwd_valid;
    logic [2*AW-1:0]   fwd_rd;
    logic [2*XLEN-1:0] fwd_data;
    logic [1:0]        fwd_ready;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              wb_long;
    logic              sb_set;
    logic [AW-1:0]     sb_rd;
    logic              stall;
    logic [31:0]       busy_vec;
    logic [CNT_W-1:0]  stall_cnt;

    id_operand_unit #(
        .XLEN(XLEN), .REG_NUM(32), .AW(AW), .NUM_READ(2), .NUM_FWD(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_used(rs_used), .rs_data(rs_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_long(wb_long),
        .sb_set(sb_set), .sb_rd(sb_rd), .stall(stall), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*AW-1:0]   rs_addr;
        logic [1:0]        rs_used;
        logic [1:0]        fv;
        logic [2*AW-1:0]   frd;
        logic [2*XLEN-1:0] fdata;
        logic [1:0]        frdy;
        logic              wb_en;
        logic [AW-1:0]     wb_addr;
        logic [XLEN-1:0]   wb_data;
        logic [XLEN-1:0]   e0;
        logic [XLEN-1:0]   e1;
        logic              es;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    int n_vec  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs_addr = '0; rs_used = '0; fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
        fwd_ready = '0; wb_en = 0; wb_addr = '0; wb_data = '0; wb_long = 0;
        sb_set = 0; sb_rd = '0;
    endtask

    function automatic int sat(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    initial begin
        vt[0]  = '{{5'd1,5'd1}, 2'b11, 2'b00, 10'd0, 64'd0, 2'b00, 1'b1, 5'd1, 32'd3, 32'd3, 32'd3, 1'b0};
        vt[1]  = '{{5'd1,5'd1}, 2'b11, 2'b00, 10'd0, 64'd0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd3, 32'd3, 1'b0};
        vt[2]  = '{{5'd2,5'd1}, 2'b11, 2'b11, {5'd1,5'd1}, {32'd20,32'd10}, 2'b11, 1'b0, 5'd0, 32'd0, 32'd10, 32'd0, 1'b0};
        vt[3]  = '{{5'd2,5'd1}, 2'b11, 2'b10, {5'd1,5'd1}, {32'd20,32'd10}, 2'b11, 1'b0, 5'd0, 32'd0, 32'd20, 32'd0, 1'b0};
        vt[4]  = '{{5'd0,5'd5}, 2'b01, 2'b01, {5'd0,5'd5}, {32'd0,32'h55}, 2'b00, 1'b0, 5'd0, 32'd0, 32'h55, 32'd0, 1'b1};
        vt[5]  = '{{5'd0,5'd5}, 2'b10, 2'b01, {5'd0,5'd5}, {32'd0,32'h55}, 2'b00, 1'b0, 5'd0, 32'd0, 32'h55, 32'd0, 1'b0};
        vt[6]  = '{{5'd0,5'd0}, 2'b11, 2'b01, {5'd0,5'd0}, {32'd0,32'h99}, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        vt[7]  = '{{5'd1,5'd3}, 2'b01, 2'b11, {5'd3,5'd3}, {32'h77,32'h33}, 2'b10, 1'b0, 5'd0, 32'd0, 32'h33, 32'd3, 1'b1};
        vt[8]  = '{{5'd4,5'd4}, 2'b11, 2'b01, {5'd0,5'd4}, {32'd0,32'h44}, 2'b01, 1'b1, 5'd4, 32'h88, 32'h44, 32'h44, 1'b0};
        vt[9]  = '{{5'd1,5'd4}, 2'b11, 2'b00, 10'd0, 64'd0, 2'b00, 1'b0, 5'd0, 32'd0, 32'h88, 32'd3, 1'b0};
        vt[10] = '{{5'd0,5'd0}, 2'b11, 2'b00, 10'd0, 64'd0, 2'b00, 1'b1, 5'd0, 32'hFFFF, 32'd0, 32'd0, 1'b0};
        vt[11] = '{{5'd1,5'd0}, 2'b11, 2'b00, 10'd0, 64'd0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'd3, 1'b0};
        vt[12] = '{{5'd6,5'd6}, 2'b11, 2'b00, 10'd0, 64'd0, 2'b00, 1'b1, 5'd6, 32'h1234, 32'h1234, 32'h1234, 1'b0};

        // Reset state, with a not-ready forward present that must be ignored.
        idle();
        rst_n = 1'b0;
        rs_addr = {5'd1,5'd1}; rs_used = 2'b11;
        fwd_valid = 2'b01; fwd_rd = {5'd0,5'd1}; fwd_data = {32'd0,32'hDEAD}; fwd_ready = 2'b00;
        #12;
        chk("reset rs_data0", rs_data[31:0], 32'd0);
        chk("reset rs_data1", rs_data[63:32], 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset busy_vec", busy_vec, 32'd0);
        chk("reset stall_cnt", {29'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rs_addr = vt[i].rs_addr; rs_used = vt[i].rs_used;
            fwd_valid = vt[i].fv; fwd_rd = vt[i].frd; fwd_data = vt[i].fdata; fwd_ready = vt[i].frdy;
            wb_en = vt[i].wb_en; wb_addr = vt[i].wb_addr; wb_data = vt[i].wb_data;
            #2;
            chk($sformatf("vec%0d rs_data0", i), rs_data[31:0], vt[i].e0);
            chk($sformatf("vec%0d rs_data1", i), rs_data[63:32], vt[i].e1);
            chk($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vt[i].es});
            chk($sformatf("vec%0d stall_cnt", i), {29'd0, stall_cnt}, sat(exp_cnt));
            if (vt[i].es) exp_cnt++;
        end

        // Scoreboard: long op on x7, stall until its writeback arrives.
        @(negedge clk);
        idle();
        sb_set = 1'b1; sb_rd = 5'd7;
        @(negedge clk);
        idle();
        rs_addr = {5'd0,5'd7}; rs_used = 2'b01;
        #2;
        chk("sb busy x7", busy_vec, 32'h0000_0080);
        chk("sb stall", {31'd0, stall}, 32'd1);
        repeat (4) @(negedge clk);
        exp_cnt += 4;
        #2;
        chk("sb stall_cnt", {29'd0, stall_cnt}, sat(exp_cnt));
        wb_en = 1'b1; wb_long = 1'b1; wb_addr = 5'd7; wb_data = 32'hABCD;
        #1;
        chk("sb wb rs_data0", rs_data[31:0], 32'h0000_ABCD);
        chk("sb wb stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        idle();
        rs_addr = {5'd0,5'd7}; rs_used = 2'b01;
        #2;
        chk("sb cleared busy", busy_vec, 32'd0);
        chk("sb file x7", rs_data[31:0], 32'h0000_ABCD);
        chk("sb cnt held", {29'd0, stall_cnt}, sat(exp_cnt));

        // Set and clear of x9 together: set wins. Set of x0 is ignored.
        @(negedge clk);
        idle();
        sb_set = 1'b1; sb_rd = 5'd9;
        wb_en = 1'b1; wb_long = 1'b1; wb_addr = 5'd9; wb_data = 32'h5;
        @(negedge clk);
        idle();
        sb_set = 1'b1; sb_rd = 5'd0;
        #2;
        chk("set wins x9", busy_vec, 32'h0000_0200);
        @(negedge clk);
        idle();
        #2;
        chk("x0 never busy", busy_vec, 32'h0000_0200);

        // Stall on x9 until the counter saturates, then reset mid-stall.
        rs_addr = {5'd1,5'd9}; rs_used = 2'b01;
        #1;
        chk("x9 stall", {31'd0, stall}, 32'd1);
        repeat (4) @(negedge clk);
        exp_cnt += 4;
        #2;
        chk("cnt saturates", {29'd0, stall_cnt}, sat(exp_cnt));
        rst_n = 1'b0;
        #1;
        chk("async rst busy", busy_vec, 32'd0);
        chk("async rst cnt", {29'd0, stall_cnt}, 32'd0);
        chk("async rst stall", {31'd0, stall}, 32'd0);
        chk("async rst x1", rs_data[63:32], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post rst stall", {31'd0, stall}, 32'd0);
        chk("post rst x1", rs_data[63:32], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
